// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI word transmitter and its helpers.
package spi_pkg;

  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT,
    DONE
  } tx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle rise and
// fall pulses taken from the synchronized value against its previous sample.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_word_tx.sv
// SPI mode-0 peripheral transmitter: FPGA logic loads one word, the MCU clocks
// it out MSB-first on sdo. sck and cs_n are oversampled by clk.
module spi_word_tx
  import spi_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  input  logic             sck,
  input  logic             cs_n,
  output logic             sdo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d_i(sck), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d_i(cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sdo_q, sdo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sdo_q   <= sdo_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sdo_d   = sdo_q;

    unique case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        if (load) begin
          hold_d  = data_in;
          shift_d = data_in;
          busy_d  = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (cs_fall) begin
          sdo_d   = shift_q[WIDTH-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // cs_n edges win over sck edges seen in the same cycle.
        if (cs_rise) begin
          sdo_d = 1'b0;
          if (cnt_q == CNT_FULL) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            shift_d = hold_q;
            cnt_d   = '0;
            state_d = ARMED;
          end
        end else if (sck_rise) begin
          if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
        end else if (sck_fall) begin
          if (cnt_q != CNT_FULL) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            sdo_d   = shift_q[WIDTH-2];
          end else begin
            sdo_d = 1'b0;
          end
        end
      end
      DONE: begin
        sdo_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sdo  = sdo_q;

endmodule

// File: tb/tb_spi_word_tx.sv
// Directed bench for spi_word_tx: table of full transfers plus hand-written
// sequences for abort, load-while-busy and reset mid-transfer.
module tb_spi_word_tx;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic        busy, done, sdo;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;

  spi_word_tx #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .busy(busy), .done(done), .sck(sck), .cs_n(cs_n), .sdo(sdo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Running tallies from the monitor; tests read deltas.
  int done_total    = 0;
  int done_and_busy = 0;
  always @(negedge clk) begin
    if (done) done_total++;
    if (done && busy) done_and_busy++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] w);
    @(negedge clk);
    load = 1'b1;
    data_in = w;
    @(negedge clk);
    load = 1'b0;
    data_in = '0;
  endtask

  // MCU side: cs_n low, n sck pulses sampling sdo at each rise, optional cs_n high.
  task automatic xfer(input int n, input bit end_cs, output logic [63:0] rx);
    rx = '0;
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < n; i++) begin
      rx = {rx[62:0], sdo};
      sck = 1'b1;
      wait_clks(HALF);
      sck = 1'b0;
      wait_clks(HALF);
    end
    if (end_cs) begin
      cs_n = 1'b1;
      wait_clks(2 * HALF);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] word;
    int          n_sck;
    logic [63:0] exp_rx;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [63:0] rx;
    int          d0, b0;
    logic        any_out;

    vecs[0] = '{"nominal",   32'hA5C3_0F81, 32, 64'h0000_0000_A5C3_0F81};
    vecs[1] = '{"overclock", 32'h8000_0001, 34, 64'h0000_0002_0000_0004};
    vecs[2] = '{"alt",       32'h5555_AAAA, 32, 64'h0000_0000_5555_AAAA};

    // Reset state
    wait_clks(3);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sdo",  sdo,  0);
    reset = 1'b0;
    wait_clks(2);

    // SPI activity with no load: outputs must stay quiet
    any_out = 1'b0;
    cs_n = 1'b0;
    for (int i = 0; i < 6 * HALF; i++) begin
      if (i % HALF == 0) sck = ~sck;
      @(negedge clk);
      any_out |= busy | done | sdo;
    end
    cs_n = 1'b1;
    sck  = 1'b0;
    for (int i = 0; i < 2 * HALF; i++) begin
      @(negedge clk);
      any_out |= busy | done | sdo;
    end
    check("idle_quiet", any_out, 0);

    // Table-driven full transfers
    foreach (vecs[k]) begin
      d0 = done_total;
      b0 = done_and_busy;
      do_load(vecs[k].word);
      check({vecs[k].name, "_busy_armed"}, busy, 1);
      xfer(vecs[k].n_sck, 1'b1, rx);
      check({vecs[k].name, "_rx"}, rx, vecs[k].exp_rx);
      check({vecs[k].name, "_done_once"}, done_total - d0, 1);
      check({vecs[k].name, "_busy_with_done"}, done_and_busy - b0, 0);
      check({vecs[k].name, "_busy_after"}, busy, 0);
      check({vecs[k].name, "_sdo_after"}, sdo, 0);
    end

    // Early abort after 12 bits, then full retry from the first bit
    d0 = done_total;
    do_load(32'hA5C3_0F81);
    xfer(12, 1'b1, rx);
    check("abort_rx12", rx, 64'hA5C);
    check("abort_no_done", done_total - d0, 0);
    check("abort_busy", busy, 1);
    xfer(32, 1'b1, rx);
    check("retry_rx", rx, 64'hA5C3_0F81);
    check("retry_done", done_total - d0, 1);
    check("retry_busy", busy, 0);

    // Load while armed is ignored
    d0 = done_total;
    do_load(32'h0000_0001);
    do_load(32'hFFFF_FFFF);
    xfer(32, 1'b1, rx);
    check("ldbusy_rx", rx, 64'h0000_0001);
    check("ldbusy_done", done_total - d0, 1);

    // Reset mid-transfer after 5 rises
    do_load(32'hFFFF_FFFF);
    xfer(5, 1'b0, rx);
    check("midrst_rx5", rx, 64'h1F);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_sdo",  sdo,  0);
    reset = 1'b0;
    cs_n = 1'b1;
    wait_clks(2 * HALF);
    check("midrst_idle_busy", busy, 0);
    d0 = done_total;
    do_load(32'h1234_5678);
    xfer(32, 1'b1, rx);
    check("postrst_rx", rx, 64'h1234_5678);
    check("postrst_done", done_total - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
